// File: rtl/sbox_word_arbiter.sv
// Round-robin arbiter sharing one 32-bit SubWord unit (optional RotWord first)
// among N_REQ requesters, with a single registered, backpressured response stage.
module sbox_word_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_word,
  input  logic [N_REQ-1:0]      req_rot,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_word,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy
);

  // AES forward S-box; entry b sits at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  logic [ID_W-1:0] ptr;
  logic            free;
  logic            gnt;
  logic [ID_W-1:0] gnt_id;
  logic [31:0]     sel_word;
  logic            sel_rot;
  logic [31:0]     eff_word;
  logic [31:0]     sub_word;
  logic [ID_W-1:0] ptr_next;

  // Grant depends only on valid bits, ptr and the response slot, never on data.
  always_comb begin
    int idx;
    idx       = 0;
    req_ready = '0;
    gnt       = 1'b0;
    gnt_id    = '0;
    free      = !rsp_valid || rsp_ready;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (rst_n && free && !gnt && req_valid[idx]) begin
        req_ready[idx] = 1'b1;
        gnt            = 1'b1;
        gnt_id         = ID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_word = req_word[32*int'(gnt_id) +: 32];
    sel_rot  = req_rot[gnt_id];
    eff_word = sel_rot ? {sel_word[23:0], sel_word[31:24]} : sel_word;
    sub_word = {sbox(eff_word[31:24]), sbox(eff_word[23:16]),
                sbox(eff_word[15:8]),  sbox(eff_word[7:0])};
    ptr_next = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_word  <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (gnt) begin
      rsp_valid <= 1'b1;
      rsp_word  <= sub_word;
      rsp_id    <= gnt_id;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign busy = rsp_valid || (|req_valid);

endmodule

// File: tb/tb_sbox_word_arbiter.sv
// Directed bench for sbox_word_arbiter: reset, SubWord/RotWord, round-robin,
// backpressure, pointer wrap and asynchronous reset mid-stream.
module tb_sbox_word_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [127:0]  req_word;
  logic [3:0]    req_rot;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_word;
  logic [1:0]    rsp_id;
  logic          rsp_ready;
  logic          busy;

  int errors = 0;
  int checks = 0;

  sbox_word_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_word(req_word),
    .req_rot(req_rot), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_word(rsp_word), .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Requester protocol monitor: a pending request must stay valid and stable.
  logic [3:0]   p_valid = '0, p_ready = '0, p_rot = '0;
  logic [127:0] p_word = '0;
  logic         p_rst = 1'b0;
  always @(posedge clk) begin
    if (p_rst && rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (p_valid[i] && !p_ready[i])
          assert (req_valid[i] && req_word[32*i +: 32] == p_word[32*i +: 32] && req_rot[i] == p_rot[i])
            else $error("requester %0d protocol violation", i);
      end
    end
    p_valid <= req_valid;
    p_ready <= req_ready;
    p_word  <= req_word;
    p_rot   <= req_rot;
    p_rst   <= rst_n;
  end

  task automatic set_req(input int i, input logic [31:0] w, input logic rot);
    req_word[32*i +: 32] = w;
    req_rot[i]           = rot;
    req_valid[i]         = 1'b1;
  endtask

  task automatic idle_cycle();
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_word = '0; req_rot = '0; rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 00000000", rsp_word); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    @(posedge clk); @(posedge clk); #2;
    req_valid = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    set_req(0, 32'h00010203, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_word !== 32'h637C777B) begin errors++; $display("FAIL single_word: got %h want 637c777b", rsp_word); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d want 0", rsp_id); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_retire: got %b want 0", rsp_valid); end
  endtask

  task automatic test_rot();
    set_req(2, 32'h00010203, 1'b1);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rot_ready: got %b want 0100", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; req_rot = '0;
    checks++; if (rsp_word !== 32'h7C777B63) begin errors++; $display("FAIL rot_word: got %h want 7c777b63", rsp_word); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL rot_id: got %0d want 2", rsp_id); end
    // Single request from 3 brings the pointer back to 0.
    set_req(3, 32'h00000000, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_id !== 2'd3 || rsp_word !== 32'h63636363) begin
      errors++; $display("FAIL rot_ptr_setup: got id %0d word %h want id 3 word 63636363", rsp_id, rsp_word); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_word [4];
    exp_word = '{32'h63636363, 32'h7C7C7C7C, 32'h77777777, 32'h7B7B7B7B};
    set_req(0, 32'h00000000, 1'b0);
    set_req(1, 32'h01010101, 1'b0);
    set_req(2, 32'h02020202, 1'b0);
    set_req(3, 32'h03030303, 1'b0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (c % 4))) begin
        errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, 4'(1 << (c % 4))); end
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) || rsp_word !== exp_word[c % 4]) begin
        errors++; $display("FAIL rr_rsp[%0d]: got v%b id %0d word %h want v1 id %0d word %h",
                           c, rsp_valid, rsp_id, rsp_word, c % 4, exp_word[c % 4]); end
      if (c >= 4) req_valid[c % 4] = 1'b0;
    end
  endtask

  task automatic test_ptr_wrap();
    set_req(0, 32'h01010101, 1'b0);
    set_req(3, 32'h02020202, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready0: got %b want 0001", req_ready); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    checks++; if (rsp_id !== 2'd0 || rsp_word !== 32'h7C7C7C7C) begin
      errors++; $display("FAIL wrap_rsp0: got id %0d word %h want id 0 word 7c7c7c7c", rsp_id, rsp_word); end
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ready3: got %b want 1000", req_ready); end
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    checks++; if (rsp_id !== 2'd3 || rsp_word !== 32'h77777777) begin
      errors++; $display("FAIL wrap_rsp3: got id %0d word %h want id 3 word 77777777", rsp_id, rsp_word); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(1, 32'h53535353, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    set_req(1, 32'h01010101, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", c, req_ready); end
      checks++; if (rsp_valid !== 1'b1 || rsp_word !== 32'hEDEDEDED || rsp_id !== 2'd1) begin
        errors++; $display("FAIL bp_hold[%0d]: got v%b id %0d word %h want v1 id 1 word edededed", c, rsp_valid, rsp_id, rsp_word); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1 || rsp_word !== 32'h7C7C7C7C || rsp_id !== 2'd1) begin
      errors++; $display("FAIL bp_next: got v%b id %0d word %h want v1 id 1 word 7c7c7c7c", rsp_valid, rsp_id, rsp_word); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    // Leave the pointer at 3 so a surviving pointer would favour requester 3.
    rsp_ready = 1'b0;
    set_req(2, 32'h00000000, 1'b0);
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", rsp_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_valid_drop: got %b want 0", rsp_valid); end
    checks++; if (rsp_word !== 32'h0) begin errors++; $display("FAIL ar_word_clear: got %h want 00000000", rsp_word); end
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 32'hFFFFFFFF, 1'b0);
    set_req(3, 32'h00000000, 1'b0);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ar_ptr_ready: got %b want 0010", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_word !== 32'h16161616 || rsp_id !== 2'd1) begin
      errors++; $display("FAIL ar_after: got v%b id %0d word %h want v1 id 1 word 16161616", rsp_valid, rsp_id, rsp_word); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (rsp_id !== 2'd3 || rsp_word !== 32'h63636363) begin
      errors++; $display("FAIL ar_next: got id %0d word %h want id 3 word 63636363", rsp_id, rsp_word); end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rot();
    test_round_robin();
    test_ptr_wrap();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
